// File: rtl/alu_pkg.sv
// ALU control codes and default widths shared by the ALU, its callers and the
// ALU-sharing arbiter.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  localparam logic [3:0] CMD_NOP  = 4'b0000;
  localparam logic [3:0] CMD_ADD  = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0011;
  localparam logic [3:0] CMD_OR   = 4'b0100;
  localparam logic [3:0] CMD_XOR  = 4'b0101;
  localparam logic [3:0] CMD_SLL  = 4'b0110;
  localparam logic [3:0] CMD_SRL  = 4'b0111;
  localparam logic [3:0] CMD_SRA  = 4'b1000;
  localparam logic [3:0] CMD_SLT  = 4'b1001;
  localparam logic [3:0] CMD_SLTU = 4'b1010;

  // Index width for a pool of n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_grant.sv
// Combinational round-robin grant: picks the first asserted request at or
// after ptr_i, wrapping modulo N.
module rr_grant #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_any_o
);

  logic             found;
  logic [IDX_W:0]   idx_v;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx_v       = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        // ptr_i < N and k < N, so one conditional subtract is a full modulo.
        idx_v = {1'b0, ptr_i} + (IDX_W + 1)'(k);
        if (idx_v >= (IDX_W + 1)'(N)) begin
          idx_v = idx_v - (IDX_W + 1)'(N);
        end
        if (!found && req_i[idx_v[IDX_W-1:0]]) begin
          found                        = 1'b1;
          grant_o[idx_v[IDX_W-1:0]]    = 1'b1;
          grant_idx_o                  = idx_v[IDX_W-1:0];
        end
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// grants and a one-entry registered, id-tagged response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*OP_W-1:0]   req_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int PTR_W = idx_width(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic               can_issue;
  logic [NUM_REQ-1:0] grant_vec;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;

  logic [DATA_W-1:0] op1_arr  [NUM_REQ];
  logic [DATA_W-1:0] op2_arr  [NUM_REQ];
  logic [OP_W-1:0]   ctrl_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op1_arr[gi]  = req_op1[gi*DATA_W +: DATA_W];
      assign op2_arr[gi]  = req_op2[gi*DATA_W +: DATA_W];
      assign ctrl_arr[gi] = req_ctrl[gi*OP_W +: OP_W];
    end
  endgenerate

  // The output register is free, or is being drained in this same cycle.
  assign can_issue = !rsp_valid_q || rsp_ready;

  rr_grant #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr_grant (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (can_issue),
    .grant_o     (grant_vec),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign req_ready = grant_vec;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (grant_any) begin
      alu_a    = op1_arr[grant_idx];
      alu_b    = op2_arr[grant_idx];
      alu_ctrl = ctrl_arr[grant_idx];
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (grant_any) begin
      // A grant while draining simply overwrites, giving one op per cycle.
      rsp_valid_d = 1'b1;
      rsp_id_d    = ID_W'(grant_idx);
      rsp_data_d  = alu_result;
      rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter with three requesters
// against a transaction-level model of grants and the response register.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_op1;
  logic [N*DW-1:0]   req_op2;
  logic [N*OW-1:0]   req_ctrl;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [OW-1:0]     alu_ctrl;
  logic [DW-1:0]     alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;

  logic [DW-1:0] op1 [N];
  logic [DW-1:0] op2 [N];
  logic [OW-1:0] ctl [N];

  int errors = 0;
  int checks = 0;

  // Reference model state: who is searched first next, and the held response.
  int          m_next;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_data;

  alu_share_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .OP_W    (OW),
    .ID_W    (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_ctrl   (req_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      CMD_ADD:  return a + b;
      CMD_SUB:  return a - b;
      CMD_AND:  return a & b;
      CMD_OR:   return a | b;
      CMD_XOR:  return a ^ b;
      CMD_SLL:  return a << b[4:0];
      CMD_SRL:  return a >> b[4:0];
      CMD_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      CMD_SLT:  return {31'b0, $signed(a) < $signed(b)};
      CMD_SLTU: return {31'b0, a < b};
      default:  return 32'h0;
    endcase
  endfunction

  // Stand-in for alu_module.
  always_comb alu_result = ref_alu(alu_a, alu_b, alu_ctrl);

  always_comb begin
    req_op1  = '0;
    req_op2  = '0;
    req_ctrl = '0;
    for (int i = 0; i < N; i++) begin
      req_op1[i*DW +: DW] = op1[i];
      req_op2[i*DW +: DW] = op2[i];
      req_ctrl[i*OW +: OW] = ctl[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were driven just after a falling edge by the caller.
  task automatic cycle(output int g);
    bit          can;
    int          idx;
    logic [N-1:0] exp_ready;
    g = -1;
    #1;
    if (!rst) begin
      can = !m_valid || rsp_ready;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_next + k) % N;
          if (req_valid[idx] && g < 0) g = idx;
        end
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("alu_a", 64'(alu_a), (g >= 0) ? 64'(op1[g]) : 64'h0);
      chk("alu_b", 64'(alu_b), (g >= 0) ? 64'(op2[g]) : 64'h0);
      chk("alu_ctrl", 64'(alu_ctrl), (g >= 0) ? 64'(ctl[g]) : 64'h0);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_id    = 0;
      m_data  = 32'h0;
      m_next  = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
      m_data  = ref_alu(op1[g], op2[g], ctl[g]);
      m_next  = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_data", 64'(rsp_data), 64'(m_data));
    $display("t=%0t rst=%0b v=%b rdy=%b grant=%0d rsp_v=%0b id=%0d data=0x%0h",
             $time, rst, req_valid, rsp_ready, g, rsp_valid, rsp_id, rsp_data);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    op1[i] = a;
    op2[i] = b;
    ctl[i] = c;
  endtask

  initial begin
    int g;
    int exp_g [4];
    logic [31:0] held_data;
    logic [IW-1:0] held_id;

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, CMD_NOP);
    m_next = 0; m_valid = 1'b0; m_id = 0; m_data = 32'h0;
    @(negedge clk);

    // Reset then idle
    cycle(g);
    cycle(g);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(g);
      chk("idle_grant", 64'(g), 64'(-1));
      chk("idle_rsp_data", 64'(rsp_data), 64'h0);
    end

    // Single request from requester 1
    set_req(1, 32'd5, 32'd7, CMD_ADD);
    req_valid = 3'b010;
    cycle(g);
    chk("single_grant", 64'(g), 64'd1);
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_id", 64'(rsp_id), 64'd1);
    chk("single_rsp_data", 64'(rsp_data), 64'd12);
    req_valid = '0;

    // Contention between requesters 0 and 1
    set_req(0, 32'd1, 32'd1, CMD_ADD);
    set_req(1, 32'd2, 32'd2, CMD_ADD);
    req_valid = 3'b011;
    exp_g = '{0, 1, 0, 1};
    for (int c = 0; c < 4; c++) begin
      cycle(g);
      chk("cont_grant", 64'(g), 64'(exp_g[c]));
      chk("cont_rsp_id", 64'(rsp_id), 64'(exp_g[c]));
      chk("cont_rsp_data", 64'(rsp_data), (exp_g[c] == 0) ? 64'd2 : 64'd4);
    end

    // Backpressure, then same-cycle drain and grant
    set_req(0, 32'd10, 32'd3, CMD_SUB);
    req_valid = 3'b001;
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int c = 0; c < 3; c++) begin
      cycle(g);
      chk("bp_grant", 64'(g), 64'(-1));
      chk("bp_data_stable", 64'(rsp_data), 64'(held_data));
      chk("bp_id_stable", 64'(rsp_id), 64'(held_id));
    end
    rsp_ready = 1'b1;
    cycle(g);
    chk("drain_grant", 64'(g), 64'd0);
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("drain_rsp_data", 64'(rsp_data), 64'd7);
    req_valid = '0;

    // Reset while a response is held
    rsp_ready = 1'b0;
    req_valid = 3'b011;
    cycle(g);
    rst = 1'b1;
    cycle(g);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycle(g);
    chk("rst_mid_grant", 64'(g), 64'd0);

    // Wrap-around from the last requester
    req_valid = 3'b100;
    set_req(2, 32'd3, 32'd4, CMD_XOR);
    cycle(g);
    chk("wrap_grant2", 64'(g), 64'd2);
    req_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      cycle(g);
      chk("wrap_rotate", 64'(g), 64'(c));
    end

    // Randomized traffic: pending requests are held until accepted or dropped
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && g != i && $urandom_range(0, 9) != 0)) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  4'($urandom_range(0, 10)));
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 49) == 0);
      cycle(g);
      if (rst) req_valid = '0;
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
